vga_sync_gen: RTL and testbench

//  Coordinate source for the stopwatch display path: produces the (x, y) pixel scan
//  and VGA hsync/vsync consumed by the per-digit segment hit-test blocks.

---
 rtl/vga_timing_pkg.sv | 40 ++++
 rtl/pixel_tick_div.sv | 44 ++++
 rtl/vga_sync_gen.sv | 131 +++++++++++++
 tb/tb_vga_sync_gen.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster timing constants, coordinate widths and the
// registered scan-output bundle used by the sync generator and hit-test blocks.
package vga_timing_pkg;

  localparam int unsigned VGA_H_VISIBLE = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;
  localparam int unsigned VGA_V_VISIBLE = 480;
  localparam int unsigned VGA_V_FRONT   = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BACK    = 33;

  localparam int unsigned VGA_H_TOTAL =
    VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int unsigned VGA_V_TOTAL =
    VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam int unsigned X_W   = 10;
  localparam int unsigned Y_W   = 9;
  localparam int unsigned CNT_W = 10;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           video_on;
    logic           hsync;
    logic           vsync;
    logic           line_start;
    logic           frame_start;
  } scan_out_t;

  // Half-open window test lo <= val < hi on raster counter values.
  function automatic logic in_window(input logic [CNT_W-1:0] val,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// System-clock to pixel-rate divider: one-clock strobe every CLK_DIV enabled clocks.
module pixel_tick_div #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic pix_tick
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             at_last_s;

  always_comb begin
    at_last_s = (div_q == DIV_LAST);
    div_d     = div_q;
    if (enable) begin
      if (at_last_s) begin
        div_d = '0;
      end else begin
        div_d = div_q + DIV_ONE;
      end
    end else begin
      div_d = div_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // Gated by enable so a frozen divider sitting on its last count never strobes.
  assign pix_tick = enable && at_last_s;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster scan generator: pixel divider, h/v counters holding the next pixel,
// and registered coordinates, sync, visible-area flag and line/frame strobes.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
  parameter int unsigned H_FRONT   = VGA_H_FRONT,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BACK    = VGA_H_BACK,
  parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
  parameter int unsigned V_FRONT   = VGA_V_FRONT,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BACK    = VGA_V_BACK,
  parameter logic        SYNC_POL  = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  output logic           pix_tick,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           video_on,
  output logic           hsync,
  output logic           vsync,
  output logic           line_start,
  output logic           frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] HS_BEG_C = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END_C = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST_C = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] VS_BEG_C = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END_C = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST_C = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic      SYNC_IDLE = ~SYNC_POL;
  localparam scan_out_t SCAN_RST  = '{
    x:           '0,
    y:           '0,
    video_on:    1'b0,
    hsync:       SYNC_IDLE,
    vsync:       SYNC_IDLE,
    line_start:  1'b0,
    frame_start: 1'b0
  };

  logic             tick_s;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  scan_out_t        scan_q, scan_d;
  scan_out_t        scan_next_s;
  logic             vis_s;
  logic             pix_tick_q;

  pixel_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .pix_tick (tick_s)
  );

  // Decode of the pixel the counters point at; becomes visible on the next tick.
  always_comb begin
    vis_s                   = (h_q < H_VIS_C) && (v_q < V_VIS_C);
    scan_next_s.video_on    = vis_s;
    scan_next_s.x           = vis_s ? h_q : '0;
    scan_next_s.y           = vis_s ? v_q[Y_W-1:0] : '0;
    scan_next_s.hsync       = in_window(h_q, HS_BEG_C, HS_END_C) ? SYNC_POL : SYNC_IDLE;
    scan_next_s.vsync       = in_window(v_q, VS_BEG_C, VS_END_C) ? SYNC_POL : SYNC_IDLE;
    scan_next_s.line_start  = (h_q == '0);
    scan_next_s.frame_start = (h_q == '0) && (v_q == '0);
  end

  always_comb begin
    h_d    = h_q;
    v_d    = v_q;
    scan_d = scan_q;
    if (tick_s) begin
      scan_d = scan_next_s;
      if (h_q == H_LAST_C) begin
        h_d = '0;
        if (v_q == V_LAST_C) begin
          v_d = '0;
        end else begin
          v_d = v_q + CNT_ONE;
        end
      end else begin
        h_d = h_q + CNT_ONE;
      end
    end else begin
      h_d    = h_q;
      v_d    = v_q;
      scan_d = scan_q;
    end
  end

  // pix_tick is registered alongside the outputs, so it flags the clock in
  // which a freshly advanced pixel is first presented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q        <= '0;
      v_q        <= '0;
      scan_q     <= SCAN_RST;
      pix_tick_q <= 1'b0;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      scan_q     <= scan_d;
      pix_tick_q <= tick_s;
    end
  end

  assign pix_tick    = pix_tick_q;
  assign x           = scan_q.x;
  assign y           = scan_q.y;
  assign video_on    = scan_q.video_on;
  assign hsync       = scan_q.hsync;
  assign vsync       = scan_q.vsync;
  assign line_start  = scan_q.line_start;
  assign frame_start = scan_q.frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench: full-size 640x480 instance (CLK_DIV=2) plus a shrunken
// raster instance (CLK_DIV=1) so whole frames and wraps fit in a short run.
module tb_vga_sync_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic       von;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
  } exp_t;

  localparam exp_t RST_E = '{x: 10'd0, y: 9'd0, von: 1'b0, hs: 1'b1,
                             vs: 1'b1, ls: 1'b0, fs: 1'b0};

  logic       clk;
  logic [1:0] rst_v;
  logic [1:0] en_v;

  logic       d0_pt, d0_von, d0_hs, d0_vs, d0_ls, d0_fs;
  logic [9:0] d0_x;
  logic [8:0] d0_y;
  logic       d1_pt, d1_von, d1_hs, d1_vs, d1_ls, d1_fs;
  logic [9:0] d1_x;
  logic [8:0] d1_y;

  int n_vec;
  int n_err;

  int cdiv [2];
  int hv [2], hf [2], hsw [2], hb [2];
  int vv [2], vf [2], vsw [2], vb [2];
  int m_div [2], m_h [2], m_v [2];
  exp_t last_e [2];
  exp_t sb0 [$];
  exp_t sb1 [$];

  int k, guard, cyc, vis, hs_low, hs_first, hs_last, fs_clk;
  int frz, fs1, ymax, vs_low, vs_bad, row;
  logic found;

  vga_sync_gen #(.CLK_DIV(2)) dut0 (
    .clk(clk), .reset(rst_v[0]), .enable(en_v[0]), .pix_tick(d0_pt),
    .x(d0_x), .y(d0_y), .video_on(d0_von), .hsync(d0_hs), .vsync(d0_vs),
    .line_start(d0_ls), .frame_start(d0_fs)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1'b0)
  ) dut1 (
    .clk(clk), .reset(rst_v[1]), .enable(en_v[1]), .pix_tick(d1_pt),
    .x(d1_x), .y(d1_y), .video_on(d1_von), .hsync(d1_hs), .vsync(d1_vs),
    .line_start(d1_ls), .frame_start(d1_fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  function automatic exp_t model_pixel(input int i);
    exp_t e;
    int   h, v;
    logic von;
    h     = m_h[i];
    v     = m_v[i];
    von   = (h < hv[i]) && (v < vv[i]);
    e.von = von;
    e.x   = von ? 10'(h) : 10'd0;
    e.y   = von ? 9'(v) : 9'd0;
    e.hs  = !((h >= hv[i] + hf[i]) && (h < hv[i] + hf[i] + hsw[i]));
    e.vs  = !((v >= vv[i] + vf[i]) && (v < vv[i] + vf[i] + vsw[i]));
    e.ls  = (h == 0);
    e.fs  = (h == 0) && (v == 0);
    return e;
  endfunction

  task automatic model_advance(input int i);
    m_h[i]++;
    if (m_h[i] == hv[i] + hf[i] + hsw[i] + hb[i]) begin
      m_h[i] = 0;
      m_v[i]++;
      if (m_v[i] == vv[i] + vf[i] + vsw[i] + vb[i]) m_v[i] = 0;
    end
  endtask

  // Model the edge that just passed, push its pixel, pop when the DUT presents one.
  task automatic proc(input int i, input logic rst_i, input logic en_i,
                      input logic obs_tick, input logic [23:0] obs);
    logic mt;
    int   qs;
    mt = 1'b0;
    if (rst_i) begin
      m_div[i]  = 0;
      m_h[i]    = 0;
      m_v[i]    = 0;
      last_e[i] = RST_E;
      if (i == 0) sb0.delete(); else sb1.delete();
    end else if (en_i) begin
      if (m_div[i] == cdiv[i] - 1) begin
        mt       = 1'b1;
        m_div[i] = 0;
        if (i == 0) sb0.push_back(model_pixel(i)); else sb1.push_back(model_pixel(i));
        model_advance(i);
      end else begin
        m_div[i]++;
      end
    end
    chk($sformatf("tick%0d", i), 32'(obs_tick), 32'(mt));
    if (obs_tick) begin
      qs = (i == 0) ? sb0.size() : sb1.size();
      chk($sformatf("sb%0d_avail", i), 32'(qs), 32'd1);
      if (qs > 0) last_e[i] = (i == 0) ? sb0.pop_front() : sb1.pop_front();
    end
    chk($sformatf("pix%0d", i), 32'(obs), 32'(last_e[i]));
  endtask

  task automatic cycle();
    @(negedge clk);
    proc(0, rst_v[0], en_v[0], d0_pt, {d0_x, d0_y, d0_von, d0_hs, d0_vs, d0_ls, d0_fs});
    proc(1, rst_v[1], en_v[1], d1_pt, {d1_x, d1_y, d1_von, d1_hs, d1_vs, d1_ls, d1_fs});
  endtask

  initial begin
    rst_v = 2'b11;
    en_v  = 2'b00;
    n_vec = 0;
    n_err = 0;
    cdiv[0] = 2; hv[0] = 640; hf[0] = 16; hsw[0] = 96; hb[0] = 48;
    vv[0] = 480; vf[0] = 10; vsw[0] = 2; vb[0] = 33;
    cdiv[1] = 1; hv[1] = 8; hf[1] = 2; hsw[1] = 3; hb[1] = 3;
    vv[1] = 6; vf[1] = 1; vsw[1] = 2; vb[1] = 1;
    for (int i = 0; i < 2; i++) begin
      m_div[i] = 0; m_h[i] = 0; m_v[i] = 0; last_e[i] = RST_E;
    end

    repeat (3) cycle();
    chk("rst_x", 32'(d0_x), 32'd0);
    chk("rst_y", 32'(d0_y), 32'd0);
    chk("rst_von", 32'(d0_von), 32'd0);
    chk("rst_hs", 32'(d0_hs), 32'd1);
    chk("rst_vs", 32'(d0_vs), 32'd1);
    chk("rst_fs", 32'(d0_fs), 32'd0);
    chk("rst_pt", 32'(d0_pt), 32'd0);

    // Row 0 sweep on the full-size raster.
    rst_v[0] = 1'b0;
    en_v[0]  = 1'b1;
    k = 0; guard = 0; vis = 0; hs_low = 0; hs_first = -1; hs_last = -1; fs_clk = 0;
    while (k < 800 && guard < 2000) begin
      cycle();
      guard++;
      if (d0_fs) fs_clk++;
      if (d0_pt) begin
        if (k == 0) begin
          chk("first_x", 32'(d0_x), 32'd0);
          chk("first_y", 32'(d0_y), 32'd0);
          chk("first_fs", 32'(d0_fs), 32'd1);
          chk("first_von", 32'(d0_von), 32'd1);
        end
        if (d0_von) vis++;
        if (!d0_hs) begin
          hs_low++;
          if (hs_first < 0) hs_first = k;
          hs_last = k;
        end
        k++;
      end
    end
    chk("row0_ticks", 32'(k), 32'd800);
    chk("row0_visible", 32'(vis), 32'd640);
    chk("hs_low_cnt", 32'(hs_low), 32'd96);
    chk("hs_first", 32'(hs_first), 32'd656);
    chk("hs_last", 32'(hs_last), 32'd751);
    chk("fs_width_clks", 32'(fs_clk), 32'd2);

    // Freeze mid-line at x=300 on row 1.
    found = 1'b0; guard = 0;
    while (!found && guard < 1000) begin
      cycle();
      guard++;
      if (d0_pt && d0_x == 10'd300) found = 1'b1;
    end
    chk("find_x300", 32'(found), 32'd1);
    en_v[0] = 1'b0;
    frz = 0;
    repeat (17) begin
      cycle();
      if (d0_pt) frz++;
      chk("frz_x", 32'(d0_x), 32'd300);
    end
    chk("frz_ticks", 32'(frz), 32'd0);
    en_v[0] = 1'b1;
    guard = 0;
    do begin
      cycle();
      guard++;
    end while (!d0_pt && guard < 10);
    chk("resume_pt", 32'(d0_pt), 32'd1);
    chk("resume_x", 32'(d0_x), 32'd301);

    // Asynchronous reset in the middle of a pixel period.
    @(posedge clk);
    #1 rst_v[0] = 1'b1;
    #1;
    chk("arst0_pix", 32'({d0_x, d0_y, d0_von, d0_hs, d0_vs, d0_ls, d0_fs}), 32'(RST_E));
    chk("arst0_pt", 32'(d0_pt), 32'd0);
    repeat (4) cycle();
    rst_v[0] = 1'b0;
    guard = 0;
    do begin
      cycle();
      guard++;
    end while (!d0_pt && guard < 10);
    chk("restart0_pt", 32'(d0_pt), 32'd1);
    chk("restart0_xy", 32'({d0_x, d0_y}), 32'd0);
    chk("restart0_fs", 32'(d0_fs), 32'd1);
    en_v[0] = 1'b0;

    // Shrunken raster, CLK_DIV=1: two full frames then the wrap.
    rst_v[1] = 1'b0;
    en_v[1]  = 1'b1;
    k = 0; cyc = 0; fs1 = 0; ymax = 0; vs_low = 0; vs_bad = 0;
    while (k < 320 && cyc < 400) begin
      cycle();
      cyc++;
      if (d1_pt) begin
        if (d1_fs) fs1++;
        if (d1_von && int'(d1_y) > ymax) ymax = int'(d1_y);
        if (!d1_vs) begin
          vs_low++;
          row = (k / 16) % 10;
          if (row != 7 && row != 8) vs_bad++;
        end
        k++;
      end
    end
    chk("s_ticks", 32'(k), 32'd320);
    chk("s_tick_every_clk", 32'(cyc), 32'd320);
    chk("s_fs_pulses", 32'(fs1), 32'd2);
    chk("s_ymax", 32'(ymax), 32'd5);
    chk("s_vs_low", 32'(vs_low), 32'd64);
    chk("s_vs_rows", 32'(vs_bad), 32'd0);
    cycle();
    chk("wrap_pt", 32'(d1_pt), 32'd1);
    chk("wrap_xy", 32'({d1_x, d1_y}), 32'd0);
    chk("wrap_fs", 32'(d1_fs), 32'd1);

    repeat (53) cycle();
    @(posedge clk);
    #1 rst_v[1] = 1'b1;
    #1;
    chk("arst1_pix", 32'({d1_x, d1_y, d1_von, d1_hs, d1_vs, d1_ls, d1_fs}), 32'(RST_E));
    chk("arst1_pt", 32'(d1_pt), 32'd0);
    repeat (3) cycle();
    rst_v[1] = 1'b0;
    cycle();
    chk("restart1_pt", 32'(d1_pt), 32'd1);
    chk("restart1_xy", 32'({d1_x, d1_y}), 32'd0);
    chk("restart1_fs", 32'(d1_fs), 32'd1);
    chk("restart1_von", 32'(d1_von), 32'd1);
    repeat (5) cycle();

    chk("sb0_left", 32'(sb0.size()), 32'd0);
    chk("sb1_left", 32'(sb1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
